// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//
// Fully synchronous, parametrised up/down modulo counter with parallel load,
// count enable, wrap-or-saturate behaviour at the ends of the range and a
// combinational terminal-count output for cascading stages. The load value
// is clamped to the top of the range, load beats en, and wrapped is a
// one-cycle registered pulse after a wrap event.
// -----------------------------------------------------------------------------
module param_updown_counter #(
   parameter int WIDTH     = 4,
   parameter int MOD       = 16,
   parameter int WRAP_MODE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrapped
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
   // One extra bit so that MOD == 2**WIDTH is still representable.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
   localparam bit               WRAP_EN = (WRAP_MODE != 0);

   logic             at_max;
   logic             at_min;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] count_next;
   logic             wrap_event;

   assign at_max = (out == MAX_VAL);
   assign at_min = (out == '0);

   // Out-of-range load values pin to the top of the range so that out never
   // holds a value >= MOD.
   assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;

   // tc is asserted in both modes; it is independent of load by design.
   assign tc = en & ((up_dn & at_max) | (~up_dn & at_min));

   // A real wrap only happens when counting (not loading) across an end of
   // the range in wrap mode; reset is resolved in the register below.
   assign wrap_event = WRAP_EN & en & ~load & tc;

   always_comb begin
      // NOTE: assign a default first so every path writes count_next and no
      // latch is inferred.
      count_next = out;
      if (load) begin
         count_next = load_clamped;
      end else if (en) begin
         if (up_dn) begin
            if (at_max) count_next = WRAP_EN ? '0 : MAX_VAL;
            else        count_next = out + WIDTH'(1);
         end else begin
            if (at_min) count_next = WRAP_EN ? MAX_VAL : '0;
            else        count_next = out - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge only, so it lives inside
      // the clocked branch and overrides load and en.
      if (reset) begin
         // NOTE: non-blocking assignments keep every register updating from
         // the same pre-edge values.
         out     <= '0;
         wrapped <= 1'b0;
      end else begin
         out     <= count_next;
         wrapped <= wrap_event;
      end
   end

endmodule
